// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default width.
package countdown_timer_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

endpackage

// File: rtl/countdown_timer_core.sv
// Count register with synchronous clear/load/decrement controls and a terminal-count flag.
module countdown_timer_core
  import countdown_timer_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         is_one
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ld) begin
      cnt_d = ld_val;
    end else if (dec) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/countdown_timer.sv
// Programmable interval timer: period register, IDLE/RUN/PAUSE control FSM and done strobe.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] period,
  input  logic         start,
  input  logic         abort,
  input  logic         pause,
  input  logic         en,
  input  logic         reload,
  output logic [W-1:0] cnt,
  output logic         busy,
  output logic         done,
  output state_e       dbg_state
);

  // Handshake: none; start/abort are single-cycle pulses, pause/reload are levels,
  // en is a tick qualifier, and done is a one-cycle strobe with no back-pressure.

  state_e       state_q, state_d;
  logic [W-1:0] per_q, per_d;
  logic         done_q, done_d;

  logic [W-1:0] p_eff;
  logic         core_clr, core_ld, core_dec;
  logic [W-1:0] core_ld_val;
  logic         is_one;

  // A load in the same cycle as start bypasses the period register.
  assign p_eff = (load && start) ? period : per_q;
  assign per_d = load ? period : per_q;

  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    core_clr    = 1'b0;
    core_ld     = 1'b0;
    core_ld_val = p_eff;
    core_dec    = 1'b0;

    if (abort) begin
      state_d  = ST_IDLE;
      core_clr = 1'b1;
    end else if (start) begin
      if (p_eff != '0) begin
        state_d = ST_RUN;
        core_ld = 1'b1;
      end else begin
        state_d  = ST_IDLE;
        core_clr = 1'b1;
        done_d   = 1'b1;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          if (en && is_one) begin
            done_d = 1'b1;
            // Reload uses the register value, so a load in this cycle takes effect next period.
            if (reload && (per_q != '0)) begin
              core_ld     = 1'b1;
              core_ld_val = per_q;
            end else begin
              core_clr = 1'b1;
              state_d  = ST_IDLE;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else if (en) begin
            core_dec = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      per_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      per_q   <= per_d;
      done_q  <= done_d;
    end
  end

  countdown_timer_core #(.W(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .clr    (core_clr),
    .ld     (core_ld),
    .ld_val (core_ld_val),
    .dec    (core_dec),
    .cnt    (cnt),
    .is_one (is_one)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer: expected {cnt,busy,done} per cycle.
module tb_countdown_timer;
  import countdown_timer_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] period = '0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         pause = 1'b0;
  logic         en = 1'b0;
  logic         reload = 1'b0;
  logic [W-1:0] cnt;
  logic         busy;
  logic         done;
  state_e       dbg_state;

  logic [W+1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  countdown_timer #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .period    (period),
    .start     (start),
    .abort     (abort),
    .pause     (pause),
    .en        (en),
    .reload    (reload),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_in(input logic ld, input logic [W-1:0] per, input logic st,
                        input logic ab, input logic ps, input logic e, input logic rl);
    load = ld; period = per; start = st; abort = ab; pause = ps; en = e; reload = rl;
  endtask

  task automatic tick(input logic [W-1:0] ec, input logic eb, input logic ed, input string nm);
    exp_q.push_back({ec, eb, ed});
    name_q.push_back(nm);
    @(posedge clk);
    #2;
  endtask

  task automatic check_now(input logic [W-1:0] ec, input logic eb, input logic ed, input string nm);
    checks++;
    if ({cnt, busy, done} !== {ec, eb, ed}) begin
      errors++;
      $display("FAIL %s: got cnt=%0d busy=%0b done=%0b, want cnt=%0d busy=%0b done=%0b",
               nm, cnt, busy, done, ec, eb, ed);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [W+1:0] e;
    string        nm;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if ({cnt, busy, done} !== e) begin
        errors++;
        $display("FAIL %s: got cnt=%0d busy=%0b done=%0b, want cnt=%0d busy=%0b done=%0b",
                 nm, cnt, busy, done, e[W+1:2], e[1], e[0]);
      end
    end
  end

  initial begin
    #3;
    check_now(8'd0, 1'b0, 1'b0, "reset_vals");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // one-shot, period 5, en always high
    set_in(1, 8'd5, 0, 0, 0, 0, 0); tick(8'd0, 0, 0, "os_load");
    set_in(0, 8'd0, 1, 0, 0, 1, 0); tick(8'd5, 1, 0, "os_start");
    set_in(0, 8'd0, 0, 0, 0, 1, 0);
    tick(8'd4, 1, 0, "os_c4");
    tick(8'd3, 1, 0, "os_c3");
    tick(8'd2, 1, 0, "os_c2");
    tick(8'd1, 1, 0, "os_c1");
    tick(8'd0, 0, 1, "os_done");
    tick(8'd0, 0, 0, "os_idle");

    // auto-reload, period 3, en every other cycle
    set_in(1, 8'd3, 0, 0, 0, 0, 1); tick(8'd0, 0, 0, "ar_load");
    set_in(0, 8'd0, 1, 0, 0, 0, 1); tick(8'd3, 1, 0, "ar_start");
    for (int r = 0; r < 2; r++) begin
      set_in(0, 8'd0, 0, 0, 0, 0, 1); tick(8'd3, 1, 0, "ar_h3");
      set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd2, 1, 0, "ar_c2");
      set_in(0, 8'd0, 0, 0, 0, 0, 1); tick(8'd2, 1, 0, "ar_h2");
      set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd1, 1, 0, "ar_c1");
      set_in(0, 8'd0, 0, 0, 0, 0, 1); tick(8'd1, 1, 0, "ar_h1");
      set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd3, 1, 1, "ar_reload");
    end

    // load 9 during reload run; load 4 at terminal count reloads old 9
    set_in(1, 8'd9, 0, 0, 0, 0, 1); tick(8'd3, 1, 0, "ld9_mid");
    set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd2, 1, 0, "ld9_c2");
    set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd1, 1, 0, "ld9_c1");
    set_in(1, 8'd4, 0, 0, 0, 1, 1); tick(8'd9, 1, 1, "ld9_reload");
    set_in(0, 8'd0, 0, 0, 0, 1, 1); tick(8'd8, 1, 0, "ld9_c8");
    set_in(0, 8'd0, 0, 1, 0, 1, 1); tick(8'd0, 0, 0, "ld9_abort");
    set_in(0, 8'd0, 1, 0, 0, 0, 0); tick(8'd4, 1, 0, "per4_start");
    set_in(0, 8'd0, 0, 1, 0, 0, 0); tick(8'd0, 0, 0, "per4_abort");

    // pause at 4, then abort at 2
    set_in(1, 8'd6, 1, 0, 0, 1, 0); tick(8'd6, 1, 0, "pa_start");
    set_in(0, 8'd0, 0, 0, 0, 1, 0); tick(8'd5, 1, 0, "pa_c5");
    tick(8'd4, 1, 0, "pa_c4");
    set_in(0, 8'd0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) tick(8'd4, 1, 0, "pa_hold");
    set_in(0, 8'd0, 0, 0, 0, 1, 0); tick(8'd4, 1, 0, "pa_release");
    tick(8'd3, 1, 0, "pa_resume3");
    tick(8'd2, 1, 0, "pa_c2");
    set_in(0, 8'd0, 0, 1, 0, 1, 0); tick(8'd0, 0, 0, "pa_abort");
    set_in(0, 8'd0, 0, 0, 0, 1, 0); tick(8'd0, 0, 0, "pa_no_done");

    // zero period and load/start bypass
    set_in(1, 8'd0, 0, 0, 0, 0, 0); tick(8'd0, 0, 0, "z_load0");
    set_in(0, 8'd0, 1, 0, 0, 0, 0); tick(8'd0, 0, 1, "z_start_done");
    set_in(0, 8'd0, 0, 0, 0, 0, 0); tick(8'd0, 0, 0, "z_after");
    set_in(1, 8'd7, 1, 0, 0, 0, 0); tick(8'd7, 1, 0, "byp_7");
    set_in(0, 8'd0, 0, 0, 0, 0, 0); tick(8'd7, 1, 0, "byp_hold");

    // start at terminal count; abort beats start
    set_in(1, 8'd2, 1, 0, 0, 1, 0); tick(8'd2, 1, 0, "col_start2");
    set_in(0, 8'd0, 0, 0, 0, 1, 0); tick(8'd1, 1, 0, "col_c1");
    set_in(0, 8'd0, 1, 0, 0, 1, 0); tick(8'd2, 1, 0, "col_restart");
    set_in(0, 8'd0, 0, 0, 0, 1, 0); tick(8'd1, 1, 0, "col_c1b");
    tick(8'd0, 0, 1, "col_done");
    set_in(0, 8'd0, 1, 1, 0, 0, 0); tick(8'd0, 0, 0, "col_abort_start");

    // asynchronous reset mid-count
    set_in(1, 8'd8, 1, 0, 0, 1, 0); tick(8'd8, 1, 0, "rs_start");
    set_in(0, 8'd0, 0, 0, 0, 1, 0);
    tick(8'd7, 1, 0, "rs_c7");
    tick(8'd6, 1, 0, "rs_c6");
    tick(8'd5, 1, 0, "rs_c5");
    #2 rst = 1'b1;
    #1 check_now(8'd0, 1'b0, 1'b0, "rs_async");
    #1 rst = 1'b0;
    tick(8'd0, 0, 0, "rs_idle1");
    tick(8'd0, 0, 0, "rs_idle2");
    set_in(0, 8'd0, 1, 0, 0, 0, 0); tick(8'd0, 0, 1, "rs_per_cleared");
    set_in(0, 8'd0, 0, 0, 0, 0, 0); tick(8'd0, 0, 0, "rs_end");

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
